bus_arbiter: RTL

- Two-master, one-slave arbiter/sequencer for the shared memory-mapped system bus.
- Master 0 is the CPU data port. Master 1 is the DMA engine.
- The granted master's address drives the system address decoder; the selected slave returns a one-cycle acknowledge.
- Provides round-robin fairness, a DMA burst lock, and a timeout that terminates accesses to unmapped or dead regions with a bus error instead of hanging the pipeline.

---
 rtl/bus_pkg.sv | 16 +
 rtl/bus_arbiter_if.sv | 58 +++++
 rtl/bus_rr_pick.sv | 25 ++
 rtl/bus_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants for the two-master system bus arbiter.
// FSM encoding, master indices, default timeout and error data.
package bus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam int TIMEOUT_DEF = 255;

  localparam logic [31:0] ERR_DATA = 32'h0;

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of CPU, DMA and slave-side bus signals.
// slave: arbiter view; master: surrounding system view.
interface bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          m0_req;
  logic          m0_we;
  logic [3:0]    m0_be;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;
  logic          m0_err;

  logic          m1_req;
  logic          m1_lock;
  logic          m1_we;
  logic [3:0]    m1_be;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;
  logic          m1_err;

  logic          s_stb;
  logic          s_we;
  logic [3:0]    s_be;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;
  logic          s_ack;

  logic          grant;
  logic          busy;

  modport slave (
    input  m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    output m0_rdata, m0_ack, m0_err,
    input  m1_req, m1_lock, m1_we, m1_be, m1_addr, m1_wdata,
    output m1_rdata, m1_ack, m1_err,
    output s_stb, s_we, s_be, s_addr, s_wdata,
    input  s_rdata, s_ack,
    output grant, busy
  );

  modport master (
    output m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack, m0_err,
    output m1_req, m1_lock, m1_we, m1_be, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack, m1_err,
    input  s_stb, s_we, s_be, s_addr, s_wdata,
    output s_rdata, s_ack,
    input  grant, busy
  );

endinterface

// File: rtl/bus_rr_pick.sv
// Two-way round-robin winner select with DMA burst lock.
// Lock overrides; a lone requester wins; a tie goes away from last_grant.
module bus_rr_pick
  import bus_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic lock_held_i,
  input  logic last_grant_i,
  output logic win_o
);

  // winner among the current requesters
  always_comb begin
    win_o = ~last_grant_i;
    if (lock_held_i && req1_i) begin
      win_o = M_DMA;
    end else if (req0_i && !req1_i) begin
      win_o = M_CPU;
    end else if (req1_i && !req0_i) begin
      win_o = M_DMA;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// CPU/DMA to single-slave bus arbiter with burst lock and timeout.
// IDLE arbitrates and latches, BUSY strobes the slave, RESP pulses ack.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.slave bus
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          lock_q, lock_d;
  logic          grant_q, grant_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic          win;
  logic          done;
  logic          tmo;
  logic [DW-1:0] rsp;

  bus_rr_pick u_pick (
    .req0_i      (bus.m0_req),
    .req1_i      (bus.m1_req),
    .lock_held_i (lock_q),
    .last_grant_i(last_q),
    .win_o       (win)
  );

  // next-state: arbitration, access tracking and response generation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    lock_d   = lock_q;
    grant_d  = grant_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = '0;
    rdata1_d = '0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;
    rsp      = '0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (!bus.m1_req) lock_d = 1'b0;
        if (bus.m0_req || bus.m1_req) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          grant_d = win;
          last_d  = win;
          lock_d  = (win == M_DMA) && bus.m1_lock;
          if (win == M_DMA) begin
            we_d    = bus.m1_we;
            be_d    = bus.m1_be;
            addr_d  = bus.m1_addr;
            wdata_d = bus.m1_wdata;
          end else begin
            we_d    = bus.m0_we;
            be_d    = bus.m0_be;
            addr_d  = bus.m0_addr;
            wdata_d = bus.m0_wdata;
          end
        end
      end
      (state_q == ST_BUSY): begin
        cnt_d = cnt_q + 8'd1;
        if (bus.s_ack) begin
          done = 1'b1;
          rsp  = we_q ? '0 : bus.s_rdata;
        end else if (cnt_q == CNT_LAST) begin
          done = 1'b1;
          tmo  = 1'b1;
          rsp  = DW'(ERR_DATA);
        end
        if (done) begin
          state_d = ST_RESP;
          if (grant_q == M_DMA) begin
            ack1_d   = 1'b1;
            err1_d   = tmo;
            rdata1_d = rsp;
          end else begin
            ack0_d   = 1'b1;
            err0_d   = tmo;
            rdata0_d = rsp;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state registers; reset aborts any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= M_DMA;
      lock_q   <= 1'b0;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      lock_q   <= lock_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  assign bus.s_stb    = (state_q == ST_BUSY);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.s_we     = we_q;
  assign bus.s_be     = be_q;
  assign bus.s_addr   = addr_q;
  assign bus.s_wdata  = wdata_q;
  assign bus.grant    = grant_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m0_ack   = ack0_q;
  assign bus.m0_err   = err0_q;
  assign bus.m1_rdata = rdata1_q;
  assign bus.m1_ack   = ack1_q;
  assign bus.m1_err   = err1_q;

endmodule
